// File: rtl/hazard_pkg.sv
// Shared types for the hazard resolution control stage: FSM states and
// forwarding-mux select encodings.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_EX_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_WB    = 2'd3;

endpackage

// File: rtl/fwd_prio_enc.sv
// Per-operand forwarding select: the youngest producer (EX, then MEM, then WB)
// wins; no match selects the register file.
module fwd_prio_enc
  import hazard_pkg::*;
(
  input  logic       i_caseA,
  input  logic       i_caseB,
  input  logic       i_caseC,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_caseA) begin
      o_sel = FWD_EXMEM;
    end else if (i_caseB) begin
      o_sel = FWD_MEMWB;
    end else if (i_caseC) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_resolve_ctrl.sv
// Stall/bubble/flush control, registered forwarding selects and saturating
// performance counters. Define HAZARD_FORWARDING_EN to enable operand forwarding.
module hazard_resolve_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             case_A1,
  input  logic             case_B1,
  input  logic             case_C1,
  input  logic             case_A2,
  input  logic             case_B2,
  input  logic             case_C2,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             ex_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e           r_state;
  logic [1:0]       r_fwdSel1;
  logic [1:0]       r_fwdSel2;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic       w_exWait;
  logic       w_branch;
  logic       w_dataStall;
  logic [1:0] w_sel1;
  logic [1:0] w_sel2;

  assign w_exWait = ~ex_ready;
  assign w_branch = ex_ready & branch_taken;

`ifdef HAZARD_FORWARDING_EN
  fwd_prio_enc u_enc1 (
    .i_caseA (case_A1),
    .i_caseB (case_B1),
    .i_caseC (case_C1),
    .o_sel   (w_sel1)
  );

  fwd_prio_enc u_enc2 (
    .i_caseA (case_A2),
    .i_caseB (case_B2),
    .i_caseC (case_C2),
    .o_sel   (w_sel2)
  );

  // Only a load still in EX cannot be forwarded; one bubble lets it reach MEM.
  assign w_dataStall = (r_state != ST_LD_STALL) & ex_mem_read &
                       (case_A1 | case_A2) & ~branch_taken & ex_ready;
`else
  logic w_unused;

  assign w_sel1 = FWD_RF;
  assign w_sel2 = FWD_RF;

  // Without forwarding every in-flight producer blocks; WB writes before the read.
  assign w_dataStall = (case_A1 | case_B1 | case_A2 | case_B2) &
                       ~branch_taken & ex_ready;
  assign w_unused    = ^{case_C1, case_C2, ex_mem_read, r_state};
`endif

  assign pc_stall     = reset & (w_exWait | w_dataStall);
  assign if_id_stall  = reset & (w_exWait | w_dataStall);
  assign id_ex_stall  = reset & w_exWait;
  assign id_ex_bubble = reset & (w_branch | w_dataStall);
  assign if_id_flush  = reset & w_branch;

  assign fwd_sel1  = r_fwdSel1;
  assign fwd_sel2  = r_fwdSel2;
  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else if (w_exWait) begin
      r_state <= ST_EX_WAIT;
    end else if (w_branch) begin
      r_state <= ST_RUN;
`ifdef HAZARD_FORWARDING_EN
    end else if (w_dataStall) begin
      r_state <= ST_LD_STALL;
`endif
    end else begin
      r_state <= ST_RUN;
    end
  end

  // Select follows the instruction into EX: held on stall, cleared with a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fwdSel1 <= FWD_RF;
      r_fwdSel2 <= FWD_RF;
    end else if (id_ex_stall) begin
      r_fwdSel1 <= r_fwdSel1;
      r_fwdSel2 <= r_fwdSel2;
    end else if (id_ex_bubble) begin
      r_fwdSel1 <= FWD_RF;
      r_fwdSel2 <= FWD_RF;
    end else begin
      r_fwdSel1 <= w_sel1;
      r_fwdSel2 <= w_sel2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (pc_stall && !(&r_stallCnt)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (if_id_flush && !(&r_flushCnt)) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_resolve_ctrl.sv
// Scoreboard bench for hazard_resolve_ctrl; expectations follow the
// HAZARD_FORWARDING_EN setting of the build.
module tb_hazard_resolve_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_A1   = 6'b100000;
  localparam logic [5:0] F_B1   = 6'b010000;
  localparam logic [5:0] F_C1   = 6'b001000;
  localparam logic [5:0] F_A2   = 6'b000100;
  localparam logic [5:0] F_B2   = 6'b000010;
  localparam logic [5:0] F_C2   = 6'b000001;

  // {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble, if_id_flush}
  localparam logic [4:0] CTL_NONE  = 5'b00000;
  localparam logic [4:0] CTL_LDUSE = 5'b11010;
  localparam logic [4:0] CTL_WAIT  = 5'b11100;
  localparam logic [4:0] CTL_BR    = 5'b00011;

  typedef struct {
    int         step;
    logic [4:0] ctl;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk;
  logic reset;
  logic [5:0] flags;
  logic exMemRead, branchTaken, exReady;
  logic pcStall, ifIdStall, idExStall, idExBubble, ifIdFlush;
  logic [1:0] fwdSel1, fwdSel2;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  exp_t expQ[$];
  exp_t monE;
  int   stepNo;
  int   checks;
  int   errors;
  logic [3:0] scEnd;
  logic [3:0] fcEnd;
  logic [3:0] scExp;

  hazard_resolve_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .case_A1      (flags[5]),
    .case_B1      (flags[4]),
    .case_C1      (flags[3]),
    .case_A2      (flags[2]),
    .case_B2      (flags[1]),
    .case_C2      (flags[0]),
    .ex_mem_read  (exMemRead),
    .branch_taken (branchTaken),
    .ex_ready     (exReady),
    .pc_stall     (pcStall),
    .if_id_stall  (ifIdStall),
    .id_ex_stall  (idExStall),
    .id_ex_bubble (idExBubble),
    .if_id_flush  (ifIdFlush),
    .fwd_sel1     (fwdSel1),
    .fwd_sel2     (fwdSel2),
    .stall_cnt    (stallCnt),
    .flush_cnt    (flushCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of inputs, queues its expected outputs, then moves to the next cycle.
  task automatic applyStimulus(input logic rst, input logic [5:0] f,
                               input logic mr, input logic bt, input logic exr,
                               input logic [4:0] ctl, input logic [1:0] s1,
                               input logic [1:0] s2, input logic [3:0] sc,
                               input logic [3:0] fc);
    exp_t e;
    reset       = rst;
    flags       = f;
    exMemRead   = mr;
    branchTaken = bt;
    exReady     = exr;
    stepNo      = stepNo + 1;
    e.step = stepNo;
    e.ctl  = ctl;
    e.sel1 = s1;
    e.sel2 = s2;
    e.sc   = sc;
    e.fc   = fc;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string what, input int step,
                             input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", what, step, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("ctl", monE.step,
                  {3'b000, pcStall, ifIdStall, idExStall, idExBubble, ifIdFlush},
                  {3'b000, monE.ctl});
      checkOutput("fwd_sel1", monE.step, {6'b0, fwdSel1}, {6'b0, monE.sel1});
      checkOutput("fwd_sel2", monE.step, {6'b0, fwdSel2}, {6'b0, monE.sel2});
      checkOutput("stall_cnt", monE.step, {4'b0, stallCnt}, {4'b0, monE.sc});
      checkOutput("flush_cnt", monE.step, {4'b0, flushCnt}, {4'b0, monE.fc});
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    stepNo      = 0;
    reset       = 1'b0;
    flags       = F_NONE;
    exMemRead   = 1'b0;
    branchTaken = 1'b0;
    exReady     = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, F_NONE, 0, 0, 1, CTL_NONE, 0, 0, 0, 0);
    applyStimulus(0, F_A1,   1, 0, 1, CTL_NONE, 0, 0, 0, 0);
    applyStimulus(1, F_NONE, 0, 0, 1, CTL_NONE, 0, 0, 0, 0);

`ifdef HAZARD_FORWARDING_EN
    applyStimulus(1, F_A1,        0, 0, 1, CTL_NONE,  0, 0, 0, 0);
    applyStimulus(1, F_B2 | F_C2, 0, 0, 1, CTL_NONE,  1, 0, 0, 0);
    applyStimulus(1, F_NONE,      0, 0, 1, CTL_NONE,  0, 2, 0, 0);
    applyStimulus(1, F_A2,        1, 0, 1, CTL_LDUSE, 0, 0, 0, 0);
    applyStimulus(1, F_B2,        0, 0, 1, CTL_NONE,  0, 0, 1, 0);
    applyStimulus(1, F_NONE,      0, 0, 1, CTL_NONE,  0, 2, 1, 0);
    applyStimulus(1, F_A1,        1, 0, 1, CTL_LDUSE, 0, 0, 1, 0);
    applyStimulus(1, F_A1,        1, 0, 1, CTL_NONE,  0, 0, 2, 0);
    applyStimulus(1, F_A2,        1, 1, 1, CTL_BR,    1, 0, 2, 0);
    applyStimulus(1, F_B1,        0, 0, 1, CTL_NONE,  0, 0, 2, 1);
    applyStimulus(1, F_A1,        0, 0, 0, CTL_WAIT,  2, 0, 2, 1);
    applyStimulus(1, F_A1,        0, 0, 0, CTL_WAIT,  2, 0, 3, 1);
    applyStimulus(1, F_A1,        0, 0, 0, CTL_WAIT,  2, 0, 4, 1);
    applyStimulus(1, F_A1,        0, 0, 0, CTL_WAIT,  2, 0, 5, 1);
    applyStimulus(1, F_A1,        0, 0, 0, CTL_WAIT,  2, 0, 6, 1);
    applyStimulus(1, F_NONE,      0, 0, 1, CTL_NONE,  2, 0, 7, 1);
    scEnd = 4'd7;
    fcEnd = 4'd1;
`else
    applyStimulus(1, F_A1,        0, 0, 1, CTL_LDUSE, 0, 0, 0, 0);
    applyStimulus(1, F_B1,        0, 0, 1, CTL_LDUSE, 0, 0, 1, 0);
    applyStimulus(1, F_B1,        0, 0, 1, CTL_LDUSE, 0, 0, 2, 0);
    applyStimulus(1, F_C1 | F_C2, 0, 0, 1, CTL_NONE,  0, 0, 3, 0);
    applyStimulus(1, F_B2,        0, 1, 1, CTL_BR,    0, 0, 3, 0);
    applyStimulus(1, F_A2,        1, 0, 1, CTL_LDUSE, 0, 0, 3, 1);
    applyStimulus(1, F_A2,        1, 0, 1, CTL_LDUSE, 0, 0, 4, 1);
    applyStimulus(1, F_NONE,      0, 0, 1, CTL_NONE,  0, 0, 5, 1);
    scEnd = 4'd5;
    fcEnd = 4'd1;
`endif

    // Reset lands in the third cycle of an EX wait.
    applyStimulus(1, F_A1,   0, 0, 0, CTL_WAIT, 0, 0, scEnd,        fcEnd);
    applyStimulus(1, F_A1,   0, 0, 0, CTL_WAIT, 0, 0, scEnd + 4'd1, fcEnd);
    applyStimulus(0, F_A1,   0, 0, 0, CTL_NONE, 0, 0, scEnd + 4'd2, fcEnd);
    applyStimulus(1, F_A1,   0, 0, 0, CTL_WAIT, 0, 0, 0, 0);
    applyStimulus(1, F_A1,   0, 0, 0, CTL_WAIT, 0, 0, 1, 0);
    applyStimulus(1, F_NONE, 0, 0, 1, CTL_NONE, 0, 0, 2, 0);

    // Long EX wait drives stall_cnt into saturation.
    for (int k = 0; k < 16; k++) begin
      scExp = (k < 13) ? 4'(2 + k) : 4'd15;
      applyStimulus(1, F_NONE, 0, 0, 0, CTL_WAIT, 0, 0, scExp, 0);
    end
    applyStimulus(1, F_NONE, 0, 0, 1, CTL_NONE, 0, 0, 15, 0);

    applyStimulus(1, F_A1,   1, 1, 0, CTL_WAIT, 0, 0, 15, 0);
    applyStimulus(1, F_A1,   1, 1, 1, CTL_BR,   0, 0, 15, 0);
    applyStimulus(1, F_NONE, 0, 0, 1, CTL_NONE, 0, 0, 15, 1);

    for (int w = 0; w < 20 && expQ.size() > 0; w++) begin
      @(negedge clk);
    end
    if (expQ.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_resolve_ctrl.md
Name: hazard_resolve_ctrl

Overview:
- Pipeline control stage directly downstream of the data hazard detector.
- Consumes the six per-operand hazard flags (A = EX, B = MEM, C = WB, each for rs1 and rs2), plus load, branch and multicycle-EX status.
- Produces stall, bubble and flush controls for the front end, and registered forwarding-mux selects that the EX stage uses one cycle later.
- Also keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of the performance counters stall_cnt and flush_cnt.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- case_A1, case_B1, case_C1  in  1 each  rs1 of the ID instruction matches rd in EX / MEM / WB.
- case_A2, case_B2, case_C2  in  1 each  rs2 of the ID instruction matches rd in EX / MEM / WB.
- ex_mem_read  in  1  instruction in EX is a load.
- branch_taken  in  1  EX resolved a taken branch or jump.
- ex_ready  in  1  EX unit done; low while a multicycle op (mul/div) is in progress.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_ex_stall  out  1  hold the ID/EX register.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- if_id_flush  out  1  load a NOP into IF/ID.
- fwd_sel1  out  2  registered rs1 operand select for EX.
- fwd_sel2  out  2  registered rs2 operand select for EX.
- stall_cnt  out  CNT_W  cycles spent in load-use stall or EX wait.
- flush_cnt  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to RUN.
  - fwd_sel1/2, stall_cnt and flush_cnt clear to 0.
  - Combinational controls are forced to 0 while reset is low.
- fwd_sel encoding: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result, 3 = WB write data.
- fwd_sel priority per operand: A > B > C (the youngest producer wins). No flags set gives 0.
- fwd_sel registration:
  - Computed from the current-cycle flags and registered at the clk edge, so it is valid while the instruction sits in EX.
  - Latency is 1 cycle.
  - Registered as 0 when id_ex_bubble is 1.
  - Held when id_ex_stall is 1.
- Load-use condition: state RUN, ex_mem_read==1, and (case_A1 or case_A2), with branch_taken==0 and ex_ready==1.
  - Same cycle: pc_stall=1, if_id_stall=1, id_ex_bubble=1.
  - Next state: LD_STALL.
- LD_STALL:
  - Lasts exactly one cycle; no stall controls asserted.
  - The load is now in MEM, so the B flag forwards it.
  - Returns to RUN.
  - A second load-use cannot trigger from LD_STALL.
- EX wait (ex_ready==0, any state):
  - pc_stall, if_id_stall and id_ex_stall are all 1; no bubble.
  - State goes to EX_WAIT and stays there while ex_ready==0.
  - The first cycle with ex_ready==1 returns to RUN with normal evaluation in that cycle.
- Branch (branch_taken==1 with ex_ready==1):
  - Same cycle: if_id_flush=1 and id_ex_bubble=1; pc_stall and if_id_stall are 0 so the PC loads the target.
  - Overrides load-use.
  - flush_cnt increments.
  - Next state: RUN.
- Simultaneous-event priority: reset > ex_ready==0 > branch_taken > load-use.
- stall_cnt: +1 in every cycle where pc_stall is 1.
- Both counters saturate at all-ones and never wrap.
- States: RUN, LD_STALL, EX_WAIT. 2-bit encoding. Unused encoding recovers to RUN.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - fwd_sel1/2 are tied to 0.
  - Any A or B flag on either operand (regardless of ex_mem_read) stalls: pc_stall=1, if_id_stall=1, id_ex_bubble=1, repeated every cycle until those flags clear.
  - C flags never stall; the register file is write-before-read.
  - LD_STALL is unreachable.
  - Branch and EX-wait priority are unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel constants FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB.
  - State constants ST_RUN, ST_LD_STALL, ST_EX_WAIT.
- One sub-module, fwd_prio_enc: combinational A>B>C priority encoder from three flags to a 2-bit select, instantiated once per operand.

Test Plan:
- Reset low for 2 cycles, then release with all inputs 0 -> all outputs 0, state RUN, counters 0.
- case_A1=1, ex_mem_read=0 for 1 cycle -> no stall; next cycle fwd_sel1=1. Then case_B2=1 and case_C2=1 together -> next cycle fwd_sel2=2.
- case_A2=1 with ex_mem_read=1 -> same cycle pc_stall, if_id_stall and id_ex_bubble all 1. Next cycle all 0 and fwd_sel2=0 (bubble). Following cycle, with case_B2=1 driven, fwd_sel2=2. stall_cnt=1.
- Load-use and branch_taken in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
- ex_ready=0 for 5 cycles with case_A1=1 -> pc_stall, if_id_stall and id_ex_stall all 1 for 5 cycles; fwd_sel1 held; stall_cnt+=5. Reset asserted in the 3rd wait cycle -> state RUN and counters 0 on the next edge.
- Force stall_cnt to all-ones with CNT_W=4 (15 stall cycles), then one more -> stays at 15. Build without HAZARD_FORWARDING_EN, case_B1=1 held 2 cycles -> stall in both cycles, fwd_sel1=0.
